// File: rtl/systolic_seq.sv
// Sequencer for an N x N output-stationary systolic MAC array: buffers A and B,
// clears the array, streams skewed operands into the west/north edges, then pulses done.
module systolic_seq #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(N*N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   go,
  output logic                   busy,
  output logic                   done,
  output logic                   array_clr,
  output logic                   array_start,
  output logic [N*WIDTH-1:0]     west_o,
  output logic [N*WIDTH-1:0]     north_o,
  input  logic [N*N*WIDTH-1:0]   array_result_i,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data
);

  localparam int NN = N*N;
  localparam int TW = $clog2(3*N-2);
  localparam logic [TW-1:0] LAST_T = TW'(3*N-3);
  localparam logic [AW:0]   NN_W   = (AW+1)'(NN);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        t_q, t_d;
  logic                 busy_q, done_q, clr_q, start_q;
  logic [N*WIDTH-1:0]   west_q, west_d, north_q, north_d;
  logic [WIDTH-1:0]     a_mem_q [NN];
  logic [WIDTH-1:0]     b_mem_q [NN];
  logic [WIDTH-1:0]     res [NN];
  logic                 wr_ok;

  // Buffers are frozen while a run is in progress, so FEED always sees the contents present at go.
  assign wr_ok = wr_en && ((state_q == S_IDLE) || (state_q == S_DONE)) && ({1'b0, wr_addr} < NN_W);

  // Operand buffer writes (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) begin
        b_mem_q[wr_addr] <= wr_data;
      end else begin
        a_mem_q[wr_addr] <= wr_data;
      end
    end
  end

  // Next-state and feed counter
  always_comb begin
    state_d = state_q;
    t_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (t_q == LAST_T) begin
          state_d = S_DONE;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Edge operands for the coming cycle: row i / column i carries element k when t = i + k.
  always_comb begin
    west_d  = '0;
    north_d = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          west_d[i*WIDTH +: WIDTH]  = west_d[i*WIDTH +: WIDTH] |
              ((int'(t_d) == i + k) ? a_mem_q[AW'(i*N+k)] : '0);
          north_d[i*WIDTH +: WIDTH] = north_d[i*WIDTH +: WIDTH] |
              ((int'(t_d) == i + k) ? b_mem_q[AW'(k*N+i)] : '0);
        end
      end
    end else begin
      west_d  = '0;
      north_d = '0;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      west_q  <= '0;
      north_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      busy_q  <= (state_d == S_CLEAR) || (state_d == S_FEED);
      done_q  <= (state_d == S_DONE);
      clr_q   <= (state_d == S_CLEAR);
      start_q <= (state_d == S_FEED);
      west_q  <= west_d;
      north_q <= north_d;
    end
  end

  // Result bus unpacked for the combinational read port
  always_comb begin
    for (int p = 0; p < NN; p++) begin
      res[p] = array_result_i[p*WIDTH +: WIDTH];
    end
  end

  assign rd_data     = res[rd_addr];
  assign busy        = busy_q;
  assign done        = done_q;
  assign array_clr   = clr_q;
  assign array_start = start_q;
  assign west_o      = west_q;
  assign north_o     = north_q;

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: N=2 and N=4 instances, each driving a behavioural PE array,
// checked cycle by cycle and against C = A x B computed directly from the matrices.
`timescale 1ns/1ps
module tb_systolic_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_n    = 2;

  logic [15:0] mA [4][4];
  logic [15:0] mB [4][4];

  logic        wr_en, wr_sel, go;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;

  // N=2 instance
  logic        s_wr_en, s_go, s_busy, s_done, s_clr, s_start;
  logic [1:0]  s_wr_addr, s_rd_addr;
  logic [15:0] s_rd_data;
  logic [31:0] s_west, s_north;
  logic [63:0] s_res;
  assign s_wr_en   = wr_en && (cur_n == 2);
  assign s_go      = go && (cur_n == 2);
  assign s_wr_addr = wr_addr[1:0];
  assign s_rd_addr = rd_addr[1:0];

  systolic_seq #(.N(2), .WIDTH(16)) u_s (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_sel(wr_sel), .wr_addr(s_wr_addr),
    .wr_data(wr_data), .go(s_go), .busy(s_busy), .done(s_done), .array_clr(s_clr),
    .array_start(s_start), .west_o(s_west), .north_o(s_north),
    .array_result_i(s_res), .rd_addr(s_rd_addr), .rd_data(s_rd_data)
  );

  // N=4 instance
  logic         l_wr_en, l_go, l_busy, l_done, l_clr, l_start;
  logic [15:0]  l_rd_data;
  logic [63:0]  l_west, l_north;
  logic [255:0] l_res;
  assign l_wr_en = wr_en && (cur_n == 4);
  assign l_go    = go && (cur_n == 4);

  systolic_seq #(.N(4), .WIDTH(16)) u_l (
    .clk(clk), .rst(rst), .wr_en(l_wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(l_go), .busy(l_busy), .done(l_done), .array_clr(l_clr),
    .array_start(l_start), .west_o(l_west), .north_o(l_north),
    .array_result_i(l_res), .rd_addr(rd_addr), .rd_data(l_rd_data)
  );

  // Behavioural PE arrays: accumulate west*north while start, registered east/south pass-through.
  logic [15:0] s_acc [2][2], s_er [2][2], s_sr [2][2], s_wi [2][2], s_ni [2][2];
  logic [15:0] l_acc [4][4], l_er [4][4], l_sr [4][4], l_wi [4][4], l_ni [4][4];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      s_wi[i][0] = s_west[i*16 +: 16];
      s_ni[0][i] = s_north[i*16 +: 16];
      for (int j = 1; j < 2; j++) begin
        s_wi[i][j] = s_er[i][j-1];
        s_ni[j][i] = s_sr[j-1][i];
      end
    end
    for (int p = 0; p < 4; p++) s_res[p*16 +: 16] = s_acc[p/2][p%2];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      l_wi[i][0] = l_west[i*16 +: 16];
      l_ni[0][i] = l_north[i*16 +: 16];
      for (int j = 1; j < 4; j++) begin
        l_wi[i][j] = l_er[i][j-1];
        l_ni[j][i] = l_sr[j-1][i];
      end
    end
    for (int p = 0; p < 16; p++) l_res[p*16 +: 16] = l_acc[p/4][p%4];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (rst || s_clr) begin
          s_acc[i][j] <= '0; s_er[i][j] <= '0; s_sr[i][j] <= '0;
        end else begin
          if (s_start) s_acc[i][j] <= s_acc[i][j] + s_wi[i][j] * s_ni[i][j];
          s_er[i][j] <= s_wi[i][j];
          s_sr[i][j] <= s_ni[i][j];
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (rst || l_clr) begin
          l_acc[i][j] <= '0; l_er[i][j] <= '0; l_sr[i][j] <= '0;
        end else begin
          if (l_start) l_acc[i][j] <= l_acc[i][j] + l_wi[i][j] * l_ni[i][j];
          l_er[i][j] <= l_wi[i][j];
          l_sr[i][j] <= l_ni[i][j];
        end
      end
    end
  end

  // View of whichever instance is under test
  logic [3:0]  g_ctl;
  logic [63:0] g_west, g_north;
  logic [15:0] g_rd;
  always_comb begin
    if (cur_n == 2) begin
      g_ctl = {s_clr, s_busy, s_start, s_done};
      g_west = {32'd0, s_west}; g_north = {32'd0, s_north}; g_rd = s_rd_data;
    end else begin
      g_ctl = {l_clr, l_busy, l_start, l_done};
      g_west = l_west; g_north = l_north; g_rd = l_rd_data;
    end
  end

  function automatic logic [15:0] ref_c(int n, int i, int j);
    logic [15:0] s;
    s = 16'd0;
    for (int k = 0; k < n; k++) s = s + mA[i][k] * mB[k][j];
    return s;
  endfunction

  function automatic logic [63:0] ref_edge(int n, int t, bit is_west);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < n; r++) begin
      int k;
      k = t - r;
      if (k >= 0 && k < n) v[r*16 +: 16] = is_west ? mA[r][k] : mB[k][r];
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        wr_en = 1'b1; wr_addr = 4'(i*n+j);
        wr_sel = 1'b0; wr_data = mA[i][j]; step();
        wr_sel = 1'b1; wr_data = mB[i][j]; step();
      end
    end
    wr_en = 1'b0;
  endtask

  // One run from go; optional disturbance during the run, reset abort at cycle abort_c, skew spot-check.
  task automatic run(input int n, input bit disturb, input int abort_c, input bit skew);
    int last;
    logic [3:0]  ec;
    logic [63:0] ew, en;
    last = 3*n;
    go = 1'b1; step(); go = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (abort_c == c) begin
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({g_ctl, g_west, g_north} !== '0) begin
          n_fail++;
          $display("FAIL abort_outputs: got ctl=%b west=%h north=%h, expected all zero", g_ctl, g_west, g_north);
        end
        #2 rst = 1'b0; go = 1'b0; wr_en = 1'b0;
        for (int d = 0; d < last + 2; d++) begin
          step();
          n_checks++;
          if (g_ctl !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_idle: cycle %0d got clr/busy/start/done=%b, expected 0000", d, g_ctl);
          end
        end
        return;
      end
      ec = {c == 1, c < last, (c >= 2) && (c < last), c == last};
      n_checks++;
      if (g_ctl !== ec) begin
        n_fail++;
        $display("FAIL ctl n=%0d cycle %0d: got clr/busy/start/done=%b, expected %b", n, c, g_ctl, ec);
      end
      ew = ((c >= 2) && (c < last)) ? ref_edge(n, c-2, 1'b1) : '0;
      en = ((c >= 2) && (c < last)) ? ref_edge(n, c-2, 1'b0) : '0;
      n_checks++;
      if (g_west !== ew || g_north !== en) begin
        n_fail++;
        $display("FAIL edges n=%0d cycle %0d: got west=%h north=%h, expected west=%h north=%h", n, c, g_west, g_north, ew, en);
      end
      if (skew && c == 5) begin
        n_checks++;
        if (g_west[63:48] !== 16'd0 || g_west[15:0] !== 16'd0 || g_north[63:48] !== 16'd4 || g_north[15:0] !== 16'd13) begin
          n_fail++;
          $display("FAIL skew_t3: got west3=%0d west0=%0d north3=%0d north0=%0d, expected 0 0 4 13",
                   g_west[63:48], g_west[15:0], g_north[63:48], g_north[15:0]);
        end
      end
      if (disturb && c < last) begin
        go = 1'b1; wr_en = 1'b1; wr_sel = 1'($urandom);
        wr_addr = 4'($urandom); wr_data = 16'($urandom);
      end else begin
        go = 1'b0; wr_en = 1'b0;
      end
      step();
    end
    go = 1'b0; wr_en = 1'b0;
    n_checks++;
    if (g_ctl !== 4'b0000) begin
      n_fail++;
      $display("FAIL after_done n=%0d: got clr/busy/start/done=%b, expected 0000", n, g_ctl);
    end
    for (int p = 0; p < n*n; p++) begin
      rd_addr = 4'(p);
      @(negedge clk);
      n_checks++;
      if (g_rd !== ref_c(n, p/n, p%n)) begin
        n_fail++;
        $display("FAIL result n=%0d idx %0d: got %0d, expected %0d", n, p, g_rd, ref_c(n, p/n, p%n));
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({s_busy, s_done, s_clr, s_start, s_west, s_north, l_busy, l_done, l_clr, l_start, l_west, l_north} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got s=%b%b%b%b l=%b%b%b%b edges s=%h/%h, expected all zero",
               s_busy, s_done, s_clr, s_start, l_busy, l_done, l_clr, l_start, s_west, s_north);
    end
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int exp1 [4];
    exp1 = '{19, 22, 43, 50};
    cur_n = 2;
    mA[0][0] = 16'd1; mA[0][1] = 16'd2; mA[1][0] = 16'd3; mA[1][1] = 16'd4;
    mB[0][0] = 16'd5; mB[0][1] = 16'd6; mB[1][0] = 16'd7; mB[1][1] = 16'd8;
    load(2);
    run(2, 1'b0, 0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      rd_addr = 4'(p);
      @(negedge clk);
      n_checks++;
      if (s_rd_data !== 16'(exp1[p])) begin
        n_fail++;
        $display("FAIL basic_const idx %0d: got %0d, expected %0d", p, s_rd_data, exp1[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    mB[0][0] = 16'd1; mB[0][1] = 16'd0; mB[1][0] = 16'd0; mB[1][1] = 16'd1;
    load(2);
    run(2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_feed_ignore();
    run(2, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    run(2, 1'b0, 4, 1'b0);
    run(2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        mA[i][j] = 16'h8000; mB[i][j] = 16'd2;
      end
    load(2);
    run(2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_identity4();
    cur_n = 4;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA[i][j] = (i == j) ? 16'd1 : 16'd0;
        mB[i][j] = 16'(4*i + j + 1);
      end
    load(4);
    run(4, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random(input int n);
    cur_n = n;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        mA[i][j] = 16'($urandom); mB[i][j] = 16'($urandom);
      end
    load(n);
    run(n, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; go = 1'b0;
    wr_addr = 4'd0; rd_addr = 4'd0; wr_data = 16'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_feed_ignore();
    test_reset_midrun();
    test_overflow();
    test_identity4();
    test_random(4);
    test_random(4);
    test_random(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
Sequencer for an N x N output-stationary systolic MAC array built from the team's PE block (per-PE inputs: start, north/west operands, result accumulator; registered east/south pass-through).
- Buffers operand matrices A (N x N) and B (N x N) written by a host.
- Clears the array, then streams skewed, zero-padded operands into the west and north edges while holding array start high.
- Signals completion; C = A x B can then be read from the PE result buses.

Parameters:
N, 4, array dimension and matrix size (N >= 2).
WIDTH, 16, operand/result width; matches PE WIDTH.
AW, $clog2(N*N), buffer address width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  reset
wr_en  in  1  host buffer write strobe
wr_sel  in  1  0 = A buffer, 1 = B buffer
wr_addr  in  AW  element index row*N+col
wr_data  in  WIDTH  element value
go  in  1  start-computation pulse
busy  out  1  high in CLEAR and FEED
done  out  1  one-cycle completion pulse
array_clr  out  1  one-cycle pulse; top ORs into PE rst
array_start  out  1  drives PE start of every PE
west_o  out  N*WIDTH  row i west operand at bits [i*WIDTH +: WIDTH]
north_o  out  N*WIDTH  column j north operand at bits [j*WIDTH +: WIDTH]
array_result_i  in  N*N*WIDTH  PE(i,j) result at [(i*N+j)*WIDTH +: WIDTH]
rd_addr  in  AW  result index i*N+j
rd_data  out  WIDTH  combinational slice of array_result_i at rd_addr

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge. All outputs and state are registered except rd_data.
- On reset:
  - state = IDLE, feed counter = 0.
  - busy, done, array_clr and array_start = 0.
  - west_o and north_o = 0.
  - A and B buffers: contents are don't-care and are not cleared.
- Buffers:
  - A writes on wr_en & ~wr_sel; B writes on wr_en & wr_sel. Writes take effect on the clock edge.
  - Writes are accepted only in IDLE and DONE; they are ignored in CLEAR and FEED.
  - wr_addr >= N*N is ignored.
- FSM, states IDLE -> CLEAR -> FEED -> DONE -> IDLE:
  - IDLE: if go = 1, next state is CLEAR. go in any other state is ignored (no queuing).
  - CLEAR (1 cycle): array_clr = 1, busy = 1, array_start = 0, edges = 0.
  - FEED (3N-2 cycles, counter t = 0 .. 3N-3): array_start = 1, busy = 1.
    - west_o row i = A[i][t-i] if 0 <= t-i < N, else 0.
    - north_o col j = B[t-j][j] if 0 <= t-j < N, else 0.
    - Next state is DONE after t = 3N-3.
  - DONE (1 cycle): done = 1, busy = 0, array_start = 0, edges = 0. Next state is IDLE.
- Latency: let cycle 0 be the cycle in which go is sampled in IDLE.
  - CLEAR = cycle 1.
  - FEED = cycles 2 .. 3N-1.
  - done = cycle 3N; all results are valid from cycle 3N onward.
  - Results stay valid until the next CLEAR.
- Correctness rationale:
  - A[i][k] and B[k][j] both reach PE(i,j) in feed cycle k+i+j.
  - Padding zeros contribute 0 products.
  - The last accumulate is at the end of t = 3N-3.
- Arithmetic: the controller performs none. Overflow/truncation to WIDTH bits is a PE property, and the bench compares modulo 2^WIDTH.
- Buffer reads during FEED use the contents frozen at go; writes cannot alter them mid-run.
- Reset mid-operation: the run is immediately abandoned and all outputs return to reset values. done is not asserted for the abandoned run.
- go held high continuously: a new run starts in the IDLE cycle following each DONE.

Test Plan:
1. N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], go pulse -> CLEAR in cycle 1; array_start high for cycles 2-5; done in cycle 6; rd_data for idx 0..3 = 19, 22, 43, 50.
2. N=4, A = identity, B[r][c] = 4r+c+1 -> C = B. Check edge skew: in feed cycle t=3, west_o row 3 = A[3][0] = 0 and row 0 = A[0][3] = 0; north_o col 3 = B[0][3] = 4; col 0 = B[3][0] = 13.
3. Back-to-back: after test 1, rewrite B = [[1,0],[0,1]] and go -> results 1, 2, 3, 4; no carryover from the prior run (array_clr pulsed once).
4. Writes and go issued during FEED -> ignored; results unchanged from the expected values; busy stays high; no second done.
5. rst asserted at feed t=2 -> busy, array_start, done, array_clr and edges are 0 asynchronously; FSM is in IDLE; no done; a subsequent go runs correctly.
6. Overflow, N=2, WIDTH=16: A = all 0x8000, B = all 2 -> every result = 0x0000 (mod 2^16); done timing unchanged.
